frame_tx_scheduler: RTL and testbench

Transmit-side counterpart of the pulse-id frame receiver. It arbitrates between NUM_REQ payload requesters (e.g. pulse-id source and auxiliary/config source) and serialises each granted payload byte-by-byte to the 8b/10b encoder. Each frame is the payload followed by its CRC-16/BUYPASS (poly 0x8005, init 0, no reflection, no xor-out), sent MSB first. Frames are separated by K28.1 comma runs. Every symbol advances only on the encoder's word tick.

---
 rtl/frame_tx_scheduler_pkg.sv | 28 ++
 rtl/frame_tx_scheduler_crc_calc.sv | 44 ++++
 rtl/frame_tx_scheduler.sv | 166 ++++++++++++++++
 tb/tb_frame_tx_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_tx_scheduler_pkg.sv
// Shared types and constants for the frame transmit path.
//   payload_t  : default payload container (9 bytes)
//   frame_t    : payload followed by its CRC-16, as seen on the wire
//   K28_1      : comma character sent between frames
//   CRC_POLY   : CRC-16/BUYPASS polynomial
//   tx_state_t : transmit scheduler state
package frame_tx_scheduler_pkg;

  localparam int PAYLOAD_BYTES_DEF = 9;

  typedef logic [PAYLOAD_BYTES_DEF*8-1:0] payload_t;

  typedef struct packed {
    payload_t    payload;
    logic [15:0] crc;
  } frame_t;

  localparam logic [7:0]  K28_1    = 8'h3C;
  localparam logic [15:0] CRC_POLY = 16'h8005;

  typedef enum logic [1:0] {
    ST_COMMA,
    ST_PAYLOAD,
    ST_CRC_HI,
    ST_CRC_LO
  } tx_state_t;

endpackage

// File: rtl/frame_tx_scheduler_crc_calc.sv
// crc_calc: MSB-first, non-reflected CRC accumulator.
//   clk, reset    : clock, synchronous active-high reset (crc <= INIT)
//   valid_i       : fold data_i into the running CRC this cycle
//   soft_reset_i  : return to INIT (takes precedence over valid_i)
//   data_i        : input word
//   crc_o         : registered CRC (after XOR_OUT)
//   crc_next_o    : CRC including data_i, available in the same cycle
module crc_calc
  import frame_tx_scheduler_pkg::*;
#(
  parameter int                  CRC_SIZE   = 16,
  parameter logic [CRC_SIZE-1:0] POLY       = CRC_POLY,
  parameter int                  DATA_WIDTH = 8,
  parameter logic [CRC_SIZE-1:0] INIT       = '0,
  parameter logic [CRC_SIZE-1:0] XOR_OUT    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  soft_reset_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o,
  output logic [CRC_SIZE-1:0]   crc_next_o
);

  logic [CRC_SIZE-1:0] crc_q;
  logic [CRC_SIZE-1:0] step;

  // Bit-serial LFSR unrolled over the input word, data MSB first.
  always_comb begin
    step = crc_q;
    for (int i = DATA_WIDTH-1; i >= 0; i--)
      step = {step[CRC_SIZE-2:0], 1'b0} ^ ((step[CRC_SIZE-1] ^ data_i[i]) ? POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (reset || soft_reset_i) crc_q <= INIT;
    else if (valid_i)          crc_q <= step;
  end

  assign crc_o      = crc_q ^ XOR_OUT;
  assign crc_next_o = step ^ XOR_OUT;

endmodule

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: arbitrates NUM_REQ payload requesters and serialises
// each granted payload, then its CRC-16/BUYPASS (MSB byte first), to the
// 8b/10b encoder. Frames are separated by at least MIN_COMMAS K28.1 commas.
// Every symbol advances only on word_tick_i.
//   clk, reset     : clock, synchronous active-high reset
//   word_tick_i    : encoder consumes data_o/comma_o this cycle
//   req_valid_i    : per-requester payload pending
//   req_payload_i  : packed payloads, requester i at slice i
//   req_ready_o    : one-cycle pulse, payload i has been latched
//   data_o/comma_o : registered symbol to encoder (comma_o=1 -> K-char)
//   frame_start_o  : pulse after payload byte 0 is consumed
//   frame_sent_o   : pulse after the CRC low byte is consumed
//   busy_o         : grant until CRC low byte consumed
module frame_tx_scheduler
  import frame_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int PAYLOAD_BYTES = $bits(payload_t)/8,
  parameter int MIN_COMMAS    = 2,
  parameter bit PRIO0         = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               word_tick_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*PAYLOAD_BYTES*8-1:0] req_payload_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [7:0]                         data_o,
  output logic                               comma_o,
  output logic                               frame_start_o,
  output logic                               frame_sent_o,
  output logic                               busy_o
);

  localparam int PW    = PAYLOAD_BYTES*8;
  localparam int IDX_W = $clog2(PAYLOAD_BYTES+1);
  localparam int CNT_W = $clog2(MIN_COMMAS+1);
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES-1);
  localparam logic [CNT_W-1:0] CNT_GO   = CNT_W'(MIN_COMMAS-1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MIN_COMMAS);
  localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_REQ-1);

  tx_state_t        state;
  logic [CNT_W-1:0] comma_cnt;
  logic [IDX_W-1:0] idx;
  logic [PW-1:0]    shift_q;
  logic [RR_W-1:0]  rr_ptr;
  logic [15:0]      crc, crc_next;

  // Arbiter: optional strict priority for requester 0, otherwise the first
  // valid requester at or after rr_ptr. Reverse scan so the lowest offset wins.
  logic [RR_W-1:0] win;
  logic            win_vld, win_rr;
  logic [PW-1:0]   win_payload;
  int              j;

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    win_rr  = 1'b0;
    j       = 0;
    if (PRIO0 && req_valid_i[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int k = NUM_REQ-1; k >= 0; k--) begin
        j = int'(rr_ptr) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (req_valid_i[j]) begin
          win     = RR_W'(j);
          win_vld = 1'b1;
          win_rr  = 1'b1;
        end
      end
    end
    win_payload = req_payload_i[int'(win)*PW +: PW];
  end

  logic grant;
  assign grant = word_tick_i && (state == ST_COMMA) && (comma_cnt >= CNT_GO) && win_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_COMMA;
      comma_cnt     <= '0;
      idx           <= '0;
      shift_q       <= '0;
      rr_ptr        <= '0;
      data_o        <= K28_1;
      comma_o       <= 1'b1;
      req_ready_o   <= '0;
      frame_start_o <= 1'b0;
      frame_sent_o  <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      req_ready_o   <= '0;
      frame_start_o <= 1'b0;
      frame_sent_o  <= 1'b0;
      if (word_tick_i) begin
        case (state)
          ST_COMMA: begin
            if (grant) begin
              req_ready_o <= NUM_REQ'(1) << win;
              if (win_rr) rr_ptr <= (win == RR_LAST) ? '0 : win + 1'b1;
              // Byte 0 goes straight to the output; the rest queue in shift_q.
              data_o    <= win_payload[PW-1 -: 8];
              shift_q   <= win_payload << 8;
              comma_o   <= 1'b0;
              busy_o    <= 1'b1;
              comma_cnt <= '0;
              idx       <= '0;
              state     <= ST_PAYLOAD;
            end else begin
              data_o  <= K28_1;
              comma_o <= 1'b1;
              if (comma_cnt != CNT_MAX) comma_cnt <= comma_cnt + 1'b1;
            end
          end
          ST_PAYLOAD: begin
            frame_start_o <= (idx == '0);
            idx           <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              // CRC register only absorbs this byte at this edge; use the
              // look-ahead value for the high byte.
              data_o <= crc_next[15:8];
              state  <= ST_CRC_HI;
            end else begin
              data_o  <= shift_q[PW-1 -: 8];
              shift_q <= shift_q << 8;
            end
          end
          ST_CRC_HI: begin
            data_o <= crc[7:0];
            state  <= ST_CRC_LO;
          end
          default: begin
            data_o       <= K28_1;
            comma_o      <= 1'b1;
            frame_sent_o <= 1'b1;
            busy_o       <= 1'b0;
            state        <= ST_COMMA;
          end
        endcase
      end
    end
  end

  // The CRC consumes exactly the byte the encoder takes on each payload tick.
  crc_calc #(
    .CRC_SIZE  (16),
    .POLY      (CRC_POLY),
    .DATA_WIDTH(8),
    .INIT      (16'h0000),
    .XOR_OUT   (16'h0000)
  ) u_crc (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (word_tick_i && (state == ST_PAYLOAD)),
    .soft_reset_i(word_tick_i && (state == ST_CRC_LO)),
    .data_i      (data_o),
    .crc_o       (crc),
    .crc_next_o  (crc_next)
  );

endmodule

// File: tb/tb_frame_tx_scheduler.sv
module tb_frame_tx_scheduler;

  localparam int NR = 3;
  localparam int PB = 9;
  localparam int MC = 2;
  localparam int PW = PB*8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             word_tick_i = 1'b0;
  logic [NR-1:0]    req_valid_i = '0;
  logic [NR*PW-1:0] req_payload_i = '0;
  logic [NR-1:0]    req_ready_o;
  logic [7:0]       data_o;
  logic             comma_o, frame_start_o, frame_sent_o, busy_o;

  always #5 clk = ~clk;

  frame_tx_scheduler #(
    .NUM_REQ(NR), .PAYLOAD_BYTES(PB), .MIN_COMMAS(MC), .PRIO0(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .word_tick_i(word_tick_i),
    .req_valid_i(req_valid_i), .req_payload_i(req_payload_i),
    .req_ready_o(req_ready_o), .data_o(data_o), .comma_o(comma_o),
    .frame_start_o(frame_start_o), .frame_sent_o(frame_sent_o), .busy_o(busy_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-at-a-time CRC-16/BUYPASS.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
    return r;
  endfunction

  // ---------------- reference model: queue of pending wire symbols ----------
  logic [7:0]    mq[$];
  logic [7:0]    rxq[$];
  int            commas = 0;
  int            rr = 0;
  logic [NR-1:0] e_ready = '0;
  logic          e_start = 1'b0, e_sent = 1'b0, e_busy = 1'b0;
  int            sent_cnt = 0;
  int            glog[$];
  logic [7:0]    sym_log[$];

  always @(negedge clk) begin
    int          w;
    logic [15:0] c;
    logic [7:0]  by;
    chk("comma", 32'(comma_o), 32'(mq.size() == 0));
    chk("data", 32'(data_o), 32'((mq.size() != 0) ? mq[0] : 8'h3C));
    chk("ready", 32'(req_ready_o), 32'(e_ready));
    chk("frame_start", 32'(frame_start_o), 32'(e_start));
    chk("frame_sent", 32'(frame_sent_o), 32'(e_sent));
    chk("busy", 32'(busy_o), 32'(e_busy));
    if (frame_sent_o === 1'b1) sent_cnt++;
    for (int i = 0; i < NR; i++) if (req_ready_o[i] === 1'b1) glog.push_back(i);
    if (word_tick_i && !reset && comma_o === 1'b0) sym_log.push_back(data_o);

    e_ready = '0; e_start = 1'b0; e_sent = 1'b0;
    if (reset) begin
      mq.delete(); rxq.delete(); commas = 0; rr = 0;
    end else if (word_tick_i) begin
      if (mq.size() != 0) begin
        if (mq.size() == PB+2) e_start = 1'b1;
        void'(mq.pop_front());
        rxq.push_back(data_o);
        if (mq.size() == 0) begin
          c = 16'h0;
          foreach (rxq[i]) c = crc_upd(c, rxq[i]);
          chk("rx_crc_residue", 32'(c), 32'h0);
          e_sent = 1'b1;
          rxq.delete();
        end
      end else if (commas >= MC-1 && req_valid_i != '0) begin
        w = -1;
        if (req_valid_i[0]) w = 0;
        else begin
          for (int k = 0; k < NR; k++) if (w < 0 && req_valid_i[(rr+k)%NR]) w = (rr+k)%NR;
          rr = (w+1) % NR;
        end
        e_ready[w] = 1'b1;
        commas = 0;
        c = 16'h0;
        for (int b = 0; b < PB; b++) begin
          by = req_payload_i[w*PW + (PB-1-b)*8 +: 8];
          c = crc_upd(c, by);
          mq.push_back(by);
        end
        mq.push_back(c[15:8]);
        mq.push_back(c[7:0]);
      end else if (commas < MC) begin
        commas++;
      end
    end
    e_busy = (mq.size() != 0);
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [NR-1:0] valid;
    logic          comma;
    logic [7:0]    data;
    logic          sent;
  } vec_t;

  vec_t       tv[15];
  logic [7:0] exp_bytes[11];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic rand_payloads();
    for (int i = 0; i < NR*PB; i++) req_payload_i[i*8 +: 8] = 8'($urandom);
  endtask

  initial begin
    int found;
    int s0;
    int exp_rr[4];
    // "123456789" frame: two commas, payload, CRC FE E8, back to commas.
    tv[0] = '{3'b001, 1'b1, 8'h3C, 1'b0};
    tv[1] = '{3'b001, 1'b1, 8'h3C, 1'b0};
    for (int i = 2; i <= 10; i++) tv[i] = '{3'b000, 1'b0, 8'(8'h31 + i - 2), 1'b0};
    tv[11] = '{3'b000, 1'b0, 8'hFE, 1'b0};
    tv[12] = '{3'b000, 1'b0, 8'hE8, 1'b0};
    tv[13] = '{3'b000, 1'b1, 8'h3C, 1'b1};
    tv[14] = '{3'b000, 1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 11; i++) exp_bytes[i] = tv[i+2].data;
    exp_rr = '{1, 2, 1, 2};

    step();
    // Idle link after reset: only commas.
    word_tick_i = 1'b1;
    do_reset();
    repeat (12) step();
    chk("idle_busy", 32'(busy_o), 32'h0);
    chk("idle_comma", 32'(comma_o), 32'h1);

    // Table-driven known-answer frame.
    req_payload_i = '0;
    req_payload_i[PW-1:0] = 72'h313233343536373839;
    do_reset();
    sym_log.delete();
    for (int i = 0; i < 15; i++) begin
      req_valid_i = tv[i].valid;
      word_tick_i = 1'b1;
      @(negedge clk);
      chk("tv_comma", 32'(comma_o), 32'(tv[i].comma));
      chk("tv_data", 32'(data_o), 32'(tv[i].data));
      chk("tv_sent", 32'(frame_sent_o), 32'(tv[i].sent));
      step();
    end

    // Same frame with a tick every 10th cycle.
    do_reset();
    sym_log.delete();
    req_valid_i = 3'b001;
    for (int c = 0; c < 400 && sym_log.size() < 11; c++) begin
      if (req_ready_o[0]) req_valid_i = '0;
      word_tick_i = (c % 10 == 9);
      step();
    end
    req_valid_i = '0;
    chk("slow_len", 32'(sym_log.size()), 32'd11);
    for (int i = 0; i < 11 && i < sym_log.size(); i++)
      chk("slow_byte", 32'(sym_log[i]), 32'(exp_bytes[i]));

    // Reset in the middle of payload byte 4.
    word_tick_i = 1'b1;
    req_payload_i[PW-1:0] = 72'hA0A1A2A3A4A5A6A7A8;
    do_reset();
    req_valid_i = 3'b001;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (req_ready_o[0]) req_valid_i = '0;
      if (comma_o == 1'b0 && data_o == 8'hA4) begin found = 1; break; end
      step();
    end
    chk("abort_reach_byte4", 32'(found), 32'h1);
    s0 = sent_cnt;
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge clk);
    chk("abort_comma_data", 32'(data_o), 32'h3C);
    req_payload_i[PW-1:0] = 72'h515253545556575859;
    req_valid_i = 3'b001;
    step();
    for (int c = 0; c < 25; c++) begin
      if (req_ready_o[0]) req_valid_i = '0;
      step();
    end
    chk("abort_sent_cnt", 32'(sent_cnt - s0), 32'h1);

    // Strict priority for requester 0, then round robin 1/2.
    rand_payloads();
    do_reset();
    glog.delete();
    req_valid_i = 3'b111;
    repeat (45) step();
    chk("prio_grants", 32'(glog.size() >= 3), 32'h1);
    foreach (glog[i]) chk("prio_order", 32'(glog[i]), 32'h0);
    do_reset();
    glog.delete();
    req_valid_i = 3'b110;
    repeat (45) step();
    chk("rr_grants", 32'(glog.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(exp_rr[i]));

    // Single requester 1: one-cycle ready, payload change afterwards is ignored.
    req_valid_i = '0;
    do_reset();
    req_payload_i[PW +: PW] = 72'hC0C1C2C3C4C5C6C7C8;
    req_valid_i = 3'b010;
    sym_log.delete();
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (req_ready_o[1]) begin found = 1; break; end
      step();
    end
    chk("req1_ready_seen", 32'(found), 32'h1);
    rand_payloads();
    req_valid_i = '0;
    step();
    chk("req1_ready_one_cycle", 32'(req_ready_o), 32'h0);
    repeat (20) step();
    chk("req1_len", 32'(sym_log.size()), 32'd11);
    for (int i = 0; i < 9 && i < sym_log.size(); i++)
      chk("req1_byte", 32'(sym_log[i]), 32'(8'hC0 + i));

    // Randomised traffic, ticks, and occasional resets against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      word_tick_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) req_valid_i = NR'($urandom);
      if ($urandom_range(0, 3) == 0) rand_payloads();
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
